// File: rtl/pe_drain_pkg.sv
// Shared constants and types for the pe_drain block.
// Optional feature macro: PE_DRAIN_RELU_EN (ReLU clamp on conv-mode words).
package pe_drain_pkg;

  localparam int DW_DEFAULT   = 16;
  localparam int FRAC_DEFAULT = 8;

  localparam logic [1:0] MODE_CONV    = 2'b00;
  localparam logic [1:0] MODE_MAXPOOL = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  function automatic logic mode_ok(input logic [1:0] mode);
    return (mode == MODE_CONV) || (mode == MODE_MAXPOOL);
  endfunction

endpackage

// File: rtl/pe_drain_buf.sv
// Snapshot register array for one PE row, plus output index/last/valid generation.
// With PE_DRAIN_RELU_EN defined, negative words are clamped to 0 when relu is high.
module pe_drain_buf
  import pe_drain_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int DATA_WIDTH = DW_DEFAULT
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cap,
  input  logic                         pop,
  input  logic                         relu,
  input  logic [NUM_PE*DATA_WIDTH-1:0] psum,
  output logic                         valid,
  output logic [DATA_WIDTH-1:0]        data,
  output logic [$clog2(NUM_PE)-1:0]    idx,
  output logic                         last
);

  localparam int IDX_W = $clog2(NUM_PE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PE - 1);

  logic [NUM_PE-1:0][DATA_WIDTH-1:0] snap;
  logic [DATA_WIDTH-1:0]             raw;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snap  <= '0;
      valid <= 1'b0;
      idx   <= '0;
    end else if (cap) begin
      snap  <= psum;
      valid <= 1'b1;
      idx   <= '0;
    end else if (pop && valid) begin
      if (idx == IDX_LAST) begin
        valid <= 1'b0;
        idx   <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  assign raw  = snap[idx];
  assign last = valid && (idx == IDX_LAST);

`ifdef PE_DRAIN_RELU_EN
  assign data = (relu && raw[DATA_WIDTH-1]) ? '0 : raw;
`else
  logic unused_relu;
  assign unused_relu = relu;
  assign data        = raw;
`endif

endmodule

// File: rtl/pe_drain.sv
// Drain stage behind a systolic PE row: tracks the tile window, snapshots all psums, streams them out.
// Optional ReLU in conv mode via PE_DRAIN_RELU_EN.
module pe_drain
  import pe_drain_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int DATA_WIDTH = DW_DEFAULT,
  parameter int FRAC_BITS  = FRAC_DEFAULT,
  parameter int PE_LAT     = 2,
  parameter int LEN_W      = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [LEN_W-1:0]             len_i,
  input  logic [1:0]                   mode_i,
  input  logic [NUM_PE*DATA_WIDTH-1:0] psum_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [DATA_WIDTH-1:0]        m_data_o,
  output logic [$clog2(NUM_PE)-1:0]    m_idx_o,
  output logic                         m_last_o,
  output logic                         busy_o,
  output logic                         err_o
);

  // Settling window after the last operand: PE latency plus skew across the row.
  localparam int WAIT_N = PE_LAT + NUM_PE - 1;
  localparam int WAIT_W = $clog2(WAIT_N + 1);
  localparam int CNT_W  = (LEN_W > WAIT_W) ? LEN_W : WAIT_W;
  localparam int unused_frac = FRAC_BITS;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             err;
  logic             conv_q;
  logic             last_wait;
  logic             drain_done;
  logic             xfer;

  assign last_wait  = (state == ST_WAIT) && (cnt == CNT_W'(1));
  assign xfer       = m_valid_o && m_ready_i;
  assign drain_done = xfer && m_last_o;

  // The counter is as wide as len_i, so a maximum length counts down fully without wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
      conv_q <= 1'b0;
    end else begin
      if (start_i && state != ST_IDLE) err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            busy   <= 1'b1;
            conv_q <= (mode_i == MODE_CONV);
            if (!mode_ok(mode_i)) err <= 1'b1;
            if (len_i == '0) begin
              state <= ST_WAIT;
              cnt   <= CNT_W'(WAIT_N);
            end else begin
              state <= ST_ACCUM;
              cnt   <= CNT_W'(len_i);
            end
          end
        end
        ST_ACCUM: begin
          if (cnt == CNT_W'(1)) begin
            state <= ST_WAIT;
            cnt   <= CNT_W'(WAIT_N);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (last_wait) begin
            state <= ST_DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = busy;
  assign err_o  = err;

  pe_drain_buf #(
    .NUM_PE     (NUM_PE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .cap    (last_wait),
    .pop    (m_ready_i),
    .relu   (conv_q),
    .psum   (psum_i),
    .valid  (m_valid_o),
    .data   (m_data_o),
    .idx    (m_idx_o),
    .last   (m_last_o)
  );

endmodule

// File: tb/tb_pe_drain.sv
// Self-checking bench for pe_drain: per-scenario tasks against a tile-level reference model.
module tb_pe_drain;
  localparam int NP  = 4;
  localparam int DW  = 16;
  localparam int LAT = 2;
`ifdef PE_DRAIN_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic          clk, rst_ni, start_i, m_ready_i;
  logic [15:0]   len_i;
  logic [1:0]    mode_i;
  logic [63:0]   psum_i;
  logic          m_valid_o, m_last_o, busy_o, err_o;
  logic [15:0]   m_data_o;
  logic [1:0]    m_idx_o;

  pe_drain #(.NUM_PE(NP), .DATA_WIDTH(DW), .FRAC_BITS(8), .PE_LAT(LAT), .LEN_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i), .mode_i(mode_i),
    .psum_i(psum_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_idx_o(m_idx_o), .m_last_o(m_last_o), .busy_o(busy_o), .err_o(err_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] expw [NP];

  // Expected word: the raw psum, or 0 for a negative conv-mode word when ReLU is built in.
  function automatic logic [15:0] ref_word(input logic [15:0] w, input logic [1:0] mode);
    if (RELU && mode == 2'b00 && $signed(w) < 0) return 16'd0;
    return w;
  endfunction

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic logic [63:0] rnd_psum();
    return {$urandom, $urandom};
  endfunction

  task automatic set_exp(input logic [63:0] p, input logic [1:0] mode);
    for (int j = 0; j < NP; j++) expw[j] = ref_word(p[j*16 +: 16], mode);
  endtask

  // Called at a negedge; the following posedge is edge 0.
  task automatic start_tile(input int len, input logic [1:0] mode, input logic [63:0] p);
    start_i = 1'b1; len_i = len[15:0]; mode_i = mode; psum_i = p;
    @(negedge clk);
    start_i = 1'b0; len_i = 16'($urandom); mode_i = 2'($urandom);
  endtask

  task automatic wait_valid(inout int n);
    while (!m_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; start_i = 1'b0; len_i = '0; mode_i = '0; psum_i = '0; m_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({m_valid_o, m_data_o, m_idx_o, m_last_o, busy_o, err_o} !== 22'd0) begin
      bad++; $display("FAIL reset_hold: got v=%0b d=%0d i=%0d l=%0b b=%0b e=%0b want all 0",
                      m_valid_o, m_data_o, m_idx_o, m_last_o, busy_o, err_o);
    end
    rst_ni = 1'b1;
    @(negedge clk);
    total++;
    if ({m_valid_o, m_data_o, m_idx_o, m_last_o, busy_o, err_o} !== 22'd0) begin
      bad++; $display("FAIL reset_release: got v=%0b d=%0d b=%0b e=%0b want all 0",
                      m_valid_o, m_data_o, busy_o, err_o);
    end
  endtask

  task automatic test_conv();
    int n = 0, k = 0, c = 0;
    logic [63:0] p = pack4(7680, -512, 256, 0);
    set_exp(p, 2'b00);
    m_ready_i = 1'b1;
    start_tile(4, 2'b00, p);
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL conv_busy: got %0b want 1", busy_o); end
    wait_valid(n);
    total++;
    if (n != 9) begin bad++; $display("FAIL conv_latency: got %0d want 9", n); end
    while (k < NP && c < 40) begin
      total++;
      if (m_valid_o !== 1'b1 || m_data_o !== expw[k] || m_idx_o !== k[1:0] || m_last_o !== (k == NP-1)) begin
        bad++; $display("FAIL conv_word%0d: got v=%0b d=%0d i=%0d l=%0b want d=%0d", k, m_valid_o,
                        $signed(m_data_o), m_idx_o, m_last_o, $signed(expw[k]));
      end
      @(negedge clk); k++; c++;
    end
    total++;
    if (busy_o !== 1'b0 || m_valid_o !== 1'b0) begin
      bad++; $display("FAIL conv_end: got b=%0b v=%0b want 0 0", busy_o, m_valid_o);
    end
  endtask

  task automatic test_maxpool();
    int n = 0, k = 0, c = 0;
    logic [63:0] p = pack4(2304, -512, -7, 100);
    set_exp(p, 2'b01);
    m_ready_i = 1'b1;
    start_tile(4, 2'b01, p);
    wait_valid(n);
    total++;
    if (n != 9) begin bad++; $display("FAIL maxpool_latency: got %0d want 9", n); end
    while (k < NP && c < 40) begin
      total++;
      if (m_valid_o !== 1'b1 || m_data_o !== expw[k] || m_idx_o !== k[1:0]) begin
        bad++; $display("FAIL maxpool_word%0d: got v=%0b d=%0d i=%0d want d=%0d", k, m_valid_o,
                        $signed(m_data_o), m_idx_o, $signed(expw[k]));
      end
      @(negedge clk); k++; c++;
    end
  endtask

  task automatic test_backpressure();
    int n = 0, k = 0, c = 0, len;
    logic rdy;
    logic [63:0] p = rnd_psum();
    len = $urandom_range(1, 5);
    set_exp(p, 2'b00);
    m_ready_i = 1'b0;
    start_tile(len, 2'b00, p);
    wait_valid(n);
    total++;
    if (n != len + LAT + NP - 1) begin bad++; $display("FAIL bp_latency: got %0d want %0d", n, len + LAT + NP - 1); end
    while (k < NP && c < 40) begin
      total++;
      if (m_valid_o !== 1'b1 || busy_o !== 1'b1 || m_data_o !== expw[k] || m_idx_o !== k[1:0] ||
          m_last_o !== (k == NP-1)) begin
        bad++; $display("FAIL bp_cycle%0d: got v=%0b b=%0b d=%0d i=%0d l=%0b want d=%0d i=%0d", c, m_valid_o,
                        busy_o, $signed(m_data_o), m_idx_o, m_last_o, $signed(expw[k]), k);
      end
      rdy = (c % 4 == 0) || (c % 4 == 3);
      m_ready_i = rdy;
      @(negedge clk); c++;
      if (rdy) k++;
    end
    m_ready_i = 1'b0;
    total++;
    if (k != NP || busy_o !== 1'b0 || m_valid_o !== 1'b0) begin
      bad++; $display("FAIL bp_end: got xfers=%0d b=%0b v=%0b want 4 0 0", k, busy_o, m_valid_o);
    end
  endtask

  task automatic test_len0_hold();
    int n = 0, k = 0, c = 0;
    logic [63:0] p = rnd_psum();
    set_exp(p, 2'b00);
    m_ready_i = 1'b1;
    start_tile(0, 2'b00, p);
    wait_valid(n);
    total++;
    if (n != 5) begin bad++; $display("FAIL len0_latency: got %0d want 5", n); end
    while (k < NP && c < 40) begin
      psum_i = rnd_psum();
      total++;
      if (m_valid_o !== 1'b1 || m_data_o !== expw[k] || m_idx_o !== k[1:0]) begin
        bad++; $display("FAIL len0_word%0d: got v=%0b d=%0d i=%0d want d=%0d", k, m_valid_o,
                        $signed(m_data_o), m_idx_o, $signed(expw[k]));
      end
      @(negedge clk); k++; c++;
    end
  endtask

  task automatic test_errors();
    int n = 0, k = 0, c = 0;
    logic [63:0] p = rnd_psum();
    total++;
    if (err_o !== 1'b0) begin bad++; $display("FAIL err_initial: got %0b want 0", err_o); end
    set_exp(p, 2'b00);
    m_ready_i = 1'b1;
    start_tile(4, 2'b00, p);
    @(negedge clk); @(negedge clk);
    start_i = 1'b1; len_i = 16'd1;
    @(negedge clk);
    start_i = 1'b0;
    n = 3;
    wait_valid(n);
    total++;
    if (n != 9 || err_o !== 1'b1) begin
      bad++; $display("FAIL err_accum: got lat=%0d err=%0b want 9 1", n, err_o);
    end
    while (k < NP && c < 40) begin
      total++;
      if (m_valid_o !== 1'b1 || m_data_o !== expw[k] || m_idx_o !== k[1:0]) begin
        bad++; $display("FAIL err_word%0d: got v=%0b d=%0d i=%0d want d=%0d", k, m_valid_o,
                        $signed(m_data_o), m_idx_o, $signed(expw[k]));
      end
      start_i = (k == 1);
      @(negedge clk); k++; c++;
      start_i = 1'b0;
    end
    total++;
    if (busy_o !== 1'b0 || err_o !== 1'b1 || m_valid_o !== 1'b0) begin
      bad++; $display("FAIL err_drain_end: got b=%0b e=%0b v=%0b want 0 1 0", busy_o, err_o, m_valid_o);
    end
    p = rnd_psum();
    set_exp(p, 2'b11);
    start_tile(2, 2'b11, p);
    n = 0; k = 0; c = 0;
    wait_valid(n);
    total++;
    if (n != 7) begin bad++; $display("FAIL err_rsv_latency: got %0d want 7", n); end
    while (k < NP && c < 40) begin
      total++;
      if (m_valid_o !== 1'b1 || m_data_o !== expw[k] || m_idx_o !== k[1:0]) begin
        bad++; $display("FAIL err_rsv_word%0d: got d=%0d want %0d", k, $signed(m_data_o), $signed(expw[k]));
      end
      @(negedge clk); k++; c++;
    end
    total++;
    if (err_o !== 1'b1) begin bad++; $display("FAIL err_sticky: got %0b want 1", err_o); end
  endtask

  task automatic test_reset_mid();
    int n = 0, k = 0, c = 0, len;
    logic [63:0] p = rnd_psum();
    m_ready_i = 1'b1;
    start_tile(3, 2'b01, p);
    wait_valid(n);
    repeat (2) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    total++;
    if ({m_valid_o, m_data_o, m_idx_o, m_last_o, busy_o, err_o} !== 22'd0) begin
      bad++; $display("FAIL rstmid_outputs: got v=%0b d=%0d i=%0d l=%0b b=%0b e=%0b want all 0",
                      m_valid_o, m_data_o, m_idx_o, m_last_o, busy_o, err_o);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    p = rnd_psum();
    len = $urandom_range(0, 6);
    set_exp(p, 2'b00);
    start_tile(len, 2'b00, p);
    n = 0;
    wait_valid(n);
    total++;
    if (n != len + LAT + NP - 1) begin bad++; $display("FAIL rstmid_latency: got %0d want %0d", n, len + LAT + NP - 1); end
    while (k < NP && c < 40) begin
      total++;
      if (m_valid_o !== 1'b1 || m_data_o !== expw[k] || m_idx_o !== k[1:0]) begin
        bad++; $display("FAIL rstmid_word%0d: got v=%0b d=%0d i=%0d want d=%0d", k, m_valid_o,
                        $signed(m_data_o), m_idx_o, $signed(expw[k]));
      end
      @(negedge clk); k++; c++;
    end
    total++;
    if (err_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_end: got e=%0b b=%0b want 0 0", err_o, busy_o);
    end
  endtask

  task automatic test_reserved();
    int n = 0;
    logic [63:0] p = rnd_psum();
    m_ready_i = 1'b1;
    start_tile(3, 2'b10, p);
    total++;
    if (err_o !== 1'b1) begin bad++; $display("FAIL rsv_err: got %0b want 1", err_o); end
    wait_valid(n);
    total++;
    if (n != 8 || m_data_o !== p[15:0]) begin
      bad++; $display("FAIL rsv_tile: got lat=%0d d0=%0d want 8 %0d", n, $signed(m_data_o), $signed(p[15:0]));
    end
    repeat (NP) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 6; t++) begin
      int n = 0, k = 0, c = 0, len;
      logic [1:0] mode;
      logic rdy;
      logic [63:0] p = rnd_psum();
      len = $urandom_range(0, 7);
      mode = 2'($urandom_range(0, 1));
      set_exp(p, mode);
      m_ready_i = 1'($urandom);
      start_tile(len, mode, p);
      wait_valid(n);
      total++;
      if (n != len + LAT + NP - 1) begin
        bad++; $display("FAIL b2b%0d_latency: got %0d want %0d", t, n, len + LAT + NP - 1);
      end
      while (k < NP && c < 60) begin
        total++;
        if (m_valid_o !== 1'b1 || m_data_o !== expw[k] || m_idx_o !== k[1:0] || m_last_o !== (k == NP-1)) begin
          bad++; $display("FAIL b2b%0d_word%0d: got v=%0b d=%0d i=%0d l=%0b want d=%0d", t, k, m_valid_o,
                          $signed(m_data_o), m_idx_o, m_last_o, $signed(expw[k]));
        end
        rdy = 1'($urandom);
        m_ready_i = rdy;
        @(negedge clk); c++;
        if (rdy) k++;
      end
      total++;
      if (k != NP || busy_o !== 1'b0) begin
        bad++; $display("FAIL b2b%0d_end: got xfers=%0d b=%0b want 4 0", t, k, busy_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_conv();
    test_maxpool();
    test_backpressure();
    test_len0_hold();
    test_errors();
    test_reset_mid();
    test_reserved();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
